// File: rtl/ahb_sram_slave.sv
// AHB slave backed by a word-addressed SRAM with programmable wait states and two-cycle ERROR responses.
// Build option: define AHB_SRAM_ROM_EN to make the lower half of the array read-only.
module ahb_sram_slave #(
  parameter int DATA_WDT    = 32,
  parameter int ADDR_WDT    = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int NBYTES = DATA_WDT / 8;
  localparam int BL     = $clog2(NBYTES);
  localparam int DEPTH  = 1 << ADDR_WDT;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_WDT-1:0] widx_q, widx_d;
  logic [BL-1:0]       boff_q, boff_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_WDT-1:0] rdata_q, rdata_d;
  logic                hready_q, hready_d;
  logic [1:0]          hresp_q, hresp_d;

  logic [DATA_WDT-1:0] mem [DEPTH];

  logic                accept, size_err, align_err, range_err, rom_err, xfer_err;
  logic [BL-1:0]       amask;
  logic [ADDR_WDT-1:0] rd_idx;
  logic                wr_commit;
  logic [NBYTES-1:0]   be;
  logic [DATA_WDT-1:0] fwd_word;
  logic                unused_bits;

  assign unused_bits = ^{i_hburst, i_htrans[0]};

  function automatic logic [NBYTES-1:0] lane_en(input logic [2:0] size, input logic [BL-1:0] off);
    logic [NBYTES-1:0] en;
    int lo, hi;
    lo = int'(off);
    hi = lo + int'(32'd1 << size);
    for (int i = 0; i < NBYTES; i++) en[i] = (i >= lo) && (i < hi);
    return en;
  endfunction

  always_comb begin
    accept    = i_hsel & i_hready & i_htrans[1];
    size_err  = i_hsize > 3'(BL);
    amask     = BL'((32'd1 << i_hsize) - 32'd1);
    align_err = |(i_haddr[BL-1:0] & amask);
    range_err = |(i_haddr >> (ADDR_WDT + BL));
`ifdef AHB_SRAM_ROM_EN
    rom_err   = i_hwrite & ~i_haddr[ADDR_WDT+BL-1];
`else
    rom_err   = 1'b0;
`endif
    xfer_err  = size_err | align_err | range_err | rom_err;
    rd_idx    = i_haddr[ADDR_WDT+BL-1:BL];
    be        = lane_en(size_q, boff_q);
    wr_commit = (state_q == ST_DATA) & wr_pend_q & ~i_hreset;

    // A read accepted while a write to the same word completes sees the new bytes.
    fwd_word = mem[rd_idx];
    for (int i = 0; i < NBYTES; i++)
      if (wr_commit && (widx_q == rd_idx) && be[i]) fwd_word[8*i +: 8] = i_hwdata[8*i +: 8];
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_pend_d = wr_pend_q;
    widx_d    = widx_q;
    boff_d    = boff_q;
    size_d    = size_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_DATA) wr_pend_d = 1'b0;

    if (accept && (state_q != ST_WAIT) && (state_q != ST_ERR1)) begin
      widx_d = rd_idx;
      boff_d = i_haddr[BL-1:0];
      size_d = i_hsize;
      if (xfer_err) begin
        state_d   = ST_ERR1;
        wr_pend_d = 1'b0;
      end else begin
        wr_pend_d = i_hwrite;
        if (WAIT_STATES == 0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
          wcnt_d  = WS_LOAD;
        end
        if (!i_hwrite) rdata_d = fwd_word;
      end
    end

    hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      wr_pend_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_pend_q <= wr_pend_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      rdata_q   <= rdata_d;
    end
    widx_q <= widx_d;
    boff_q <= boff_d;
    size_q <= size_d;
  end

  always_ff @(posedge i_hclk) begin
    for (int i = 0; i < NBYTES; i++)
      if (wr_commit && be[i]) mem[widx_q][8*i +: 8] <= i_hwdata[8*i +: 8];
  end

  assign o_hrdata = rdata_q;
  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;

endmodule
